// File: rtl/axis_insert_header_v2.sv
// Purpose : prefixes every AXI-Stream packet with an N-byte header (N = 1..DATA_BYTE_WD, per packet).
// Latency : first output beat one cycle after the first payload handshake; one beat per clock sustained.
// Backpres: registered output stage; ready_in = !valid_out || ready_out, so stalls never drop or repeat beats.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   valid_in/data_in/keep_in/last_in/ready_in
//                                  payload stream, byte 0 in the MSBs, keep MSB-aligned on the last beat
//   valid_out/data_out/keep_out/last_out/ready_out
//                                  merged stream, all registered, unused bytes driven to zero
//   valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert
//                                  header, N = byte_insert_cnt+1 valid bytes in the LSBs
//   pkt_cnt                        wrapping count of packets that left on the output
//   err_keep                       pulse in the header handshake cycle when keep_insert != (1<<N)-1

module axis_insert_header_v2 #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int CNT_WD       = 16
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,

   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,

   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
   output logic                    ready_insert,

   output logic [CNT_WD-1:0]       pkt_cnt,
   output logic                    err_keep
);

   // NB_WD holds a byte count 0..B, TB_WD holds N+k up to 2B,
   // SH_WD holds a bit shift 0..8B.
   localparam int NB_WD = BYTE_CNT_WD + 1;
   localparam int TB_WD = BYTE_CNT_WD + 2;
   localparam int SH_WD = NB_WD + 3;
   localparam logic [NB_WD-1:0] B_CNT = NB_WD'(DATA_BYTE_WD);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FLUSH  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WD-1:0]      dat;
      logic [DATA_BYTE_WD-1:0] keep;
      logic                    last;
   } beat_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic [NB_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] v);
      logic [NB_WD-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         c = c + NB_WD'(v[i]);
      end
      return c;
   endfunction

   // Top t byte-enable bits set (MSB-aligned keep).
   function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [TB_WD-1:0] t);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         m[DATA_BYTE_WD-1-i] = (i < int'(t));
      end
      return m;
   endfunction

   // Low n byte-enable bits set (expected keep_insert).
   function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [NB_WD-1:0] n);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         m[i] = (i < int'(n));
      end
      return m;
   endfunction

   // Expand byte enables into a bit mask.
   function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         m[8*i +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t               state, state_nxt;
   logic [NB_WD-1:0]     hdr_n;    // N for the packet in flight
   logic [DATA_WD-1:0]   resid;    // carried bytes, left-justified, low bytes zero
   logic [NB_WD-1:0]     ovf_n;    // T-B bytes still owed by the flush beat
   beat_t                out_q;
   logic                 out_vld;

   logic                 out_free;
   logic                 in_hs;
   logic                 hdr_hs;
   logic                 out_hs;
   logic                 load_out;
   beat_t                beat_nxt;

   logic [NB_WD-1:0]     hdr_n_nxt;
   logic [SH_WD-1:0]     sh_hdr;
   logic [SH_WD-1:0]     sh_rem;
   logic [SH_WD-1:0]     sh_ins;
   logic [DATA_WD-1:0]   data_m;
   logic [DATA_WD-1:0]   merged;
   logic [DATA_WD-1:0]   resid_in;
   logic [NB_WD-1:0]     k_cnt;
   logic [TB_WD-1:0]     t_cnt;
   logic [NB_WD-1:0]     ovf_nxt;
   logic                 spill;

   assign out_free = !out_vld || ready_out;
   assign in_hs    = valid_in && ready_in;
   assign hdr_hs   = valid_insert && ready_insert;
   assign out_hs   = out_vld && ready_out;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (hdr_hs) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (in_hs && last_in) state_nxt = spill ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            // Leaving as soon as the flush beat is loaded gives the one-cycle
            // IDLE gap before the next header.
            if (out_free) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: handshake outputs (held low while reset is asserted)
   // ------------------------------------------------------------------
   always_comb begin
      ready_insert = 1'b0;
      ready_in     = 1'b0;
      case (state)
         S_IDLE:   ready_insert = !rst;
         S_STREAM: ready_in     = out_free && !rst;
         default: begin
            ready_insert = 1'b0;
            ready_in     = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Byte realignment
   // ------------------------------------------------------------------
   always_comb begin
      hdr_n_nxt = {1'b0, byte_insert_cnt} + NB_WD'(1);
      sh_ins    = {B_CNT - hdr_n_nxt, 3'b000};
      sh_hdr    = {hdr_n, 3'b000};
      sh_rem    = {B_CNT - hdr_n, 3'b000};

      // Mask first so bytes beyond keep can never leak into data_out.
      data_m    = data_in & byte_mask(keep_in);
      // A shift by the full bus width (N==B) yields zero, so the whole
      // beat comes from the residual and payload slips by one beat.
      merged    = resid | (data_m >> sh_hdr);
      resid_in  = data_m << sh_rem;

      k_cnt     = popcnt(keep_in);
      t_cnt     = {1'b0, hdr_n} + {1'b0, k_cnt};
      spill     = t_cnt > {1'b0, B_CNT};
      // Modulo NB_WD is exact here: T-B never exceeds B.
      ovf_nxt   = hdr_n + k_cnt - B_CNT;

      beat_nxt  = '0;
      load_out  = 1'b0;
      case (state)
         S_STREAM: begin
            load_out      = in_hs;
            beat_nxt.dat  = merged;
            beat_nxt.last = last_in && !spill;
            beat_nxt.keep = (last_in && !spill) ? top_mask(t_cnt) : '1;
         end
         S_FLUSH: begin
            load_out      = out_free;
            beat_nxt.dat  = resid;
            beat_nxt.keep = top_mask({1'b0, ovf_n});
            beat_nxt.last = 1'b1;
         end
         default: begin
            load_out = 1'b0;
            beat_nxt = '0;
         end
      endcase
   end

   // Header byte count / residual / flush length
   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_n <= '0;
         resid <= '0;
         ovf_n <= '0;
      end else if (hdr_hs) begin
         hdr_n <= hdr_n_nxt;
         // Shifting up drops the unused upper header bytes.
         resid <= data_insert << sh_ins;
      end else if (in_hs) begin
         resid <= resid_in;
         if (last_in && spill) ovf_n <= ovf_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         out_vld <= 1'b0;
      end else if (load_out) begin
         out_q   <= beat_nxt;
         out_vld <= 1'b1;
      end else if (ready_out) begin
         out_vld <= 1'b0;
      end
   end

   assign valid_out = out_vld;
   assign data_out  = out_q.dat;
   assign keep_out  = out_q.keep;
   assign last_out  = out_q.last;

   // ------------------------------------------------------------------
   // Packet counter and header keep check
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt <= '0;
      end else if (out_hs && out_q.last) begin
         pkt_cnt <= pkt_cnt + 1'b1;
      end
   end

   assign err_keep = hdr_hs && (keep_insert != low_mask(hdr_n_nxt));

endmodule

// File: tb/tb_axis_insert_header_v2.sv
module tb_axis_insert_header_v2;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        last_in;
   logic        ready_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out;
   logic        valid_insert;
   logic [31:0] data_insert;
   logic [3:0]  keep_insert;
   logic [1:0]  byte_insert_cnt;
   logic        ready_insert;
   logic [15:0] pkt_cnt;
   logic        err_keep;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] mb[$];
   int         n_chk = 0;
   int         n_err = 0;
   logic       rand_rdy = 1'b0;
   logic       rdy_force = 1'b1;

   axis_insert_header_v2 #(
      .DATA_WD (32),
      .CNT_WD  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_insert    (valid_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert),
      .pkt_cnt         (pkt_cnt),
      .err_keep        (err_keep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ready: forced value or a coin flip each cycle.
   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      beat_t b;
      b.d = d;
      b.k = k;
      b.l = l;
      exp_q.push_back(b);
   endtask

   // Reference model: chop the packet byte queue into MSB-first beats.
   task automatic emit_model();
      logic [31:0] d;
      logic [3:0]  k;
      while (mb.size() > 0) begin
         d = '0;
         k = '0;
         for (int i = 0; i < 4; i++) begin
            if (mb.size() > 0) begin
               d[31-8*i -: 8] = mb.pop_front();
               k[3-i] = 1'b1;
            end
         end
         push_exp(d, k, mb.size() == 0);
      end
   endtask

   task automatic send_hdr(input logic [1:0] cnt, input logic [31:0] d, input logic [3:0] k,
                           output logic err);
      int t = 0;
      valid_insert    = 1'b1;
      data_insert     = d;
      keep_insert     = k;
      byte_insert_cnt = cnt;
      @(negedge clk);
      while (!ready_insert && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("hdr_hs", ready_insert, 1);
      err = err_keep;
      @(posedge clk);
      #1;
      valid_insert = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t = 0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      @(negedge clk);
      while (!ready_in && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("in_hs", ready_in, 1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 4000) begin
         @(posedge clk);
         t++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard compare and stall stability.
   initial begin
      beat_t held;
      beat_t b;
      logic  stalled;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               chk("stall_vld", valid_out, 1);
               chk("stall_hold", {data_out, keep_out, last_out}, held);
            end
            stalled = valid_out && !ready_out;
            held    = {data_out, keep_out, last_out};
            if (valid_out && ready_out) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", valid_out, 0);
               end else begin
                  b = exp_q.pop_front();
                  chk("out_dat", data_out, b.d);
                  chk("out_keep", keep_out, b.k);
                  chk("out_last", last_out, b.l);
               end
            end
         end
      end
   end

   initial begin
      logic e;
      rst = 1'b1;
      valid_in = 1'b0;  data_in = '0;  keep_in = '0;  last_in = 1'b0;
      valid_insert = 1'b0;  data_insert = '0;  keep_insert = '0;  byte_insert_cnt = '0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_vld", valid_out, 0);
      chk("rst_last", last_out, 0);
      chk("rst_dat", data_out, 0);
      chk("rst_keep", keep_out, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_err", err_keep, 0);
      chk("rst_rdy_in", ready_in, 0);
      chk("rst_rdy_ins", ready_insert, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rdy_ins", ready_insert, 1);
      chk("post_rst_rdy_in", ready_in, 0);

      // Payload offered in IDLE is ignored
      @(posedge clk);
      #1;
      valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = 4'hF; last_in = 1'b1;
      @(negedge clk);
      chk("idle_rdy_in", ready_in, 0);
      @(posedge clk);
      #1;
      valid_in = 1'b0; last_in = 1'b0;
      @(negedge clk);
      chk("idle_no_out", valid_out, 0);
      @(posedge clk);
      #1;

      // N=2, two full payload beats, spill into a flush beat
      push_exp(32'hAABB1122, 4'b1111, 1'b0);
      push_exp(32'h33445566, 4'b1111, 1'b0);
      push_exp(32'h77880000, 4'b1100, 1'b1);
      send_hdr(2'd1, 32'h0000AABB, 4'b0011, e);
      chk("t1_err", e, 0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      @(negedge clk);
      chk("t1_latency", valid_out, 1);
      @(posedge clk);
      #1;
      send_beat(32'h55667788, 4'hF, 1'b1);
      drain();
      chk("t1_pkt", pkt_cnt, 1);
      chk("t1_idle_vld", valid_out, 0);

      // N=1, single partial beat fills exactly one output beat
      push_exp(32'hCC123456, 4'b1111, 1'b1);
      send_hdr(2'd0, 32'h000000CC, 4'b0001, e);
      @(negedge clk);
      chk("t2_rdy_ins_stream", ready_insert, 0);
      chk("t2_rdy_in_stream", ready_in, 1);
      @(posedge clk);
      #1;
      send_beat(32'h12345600, 4'b1110, 1'b1);
      drain();
      chk("t2_pkt", pkt_cnt, 2);

      // N=B, payload delayed by one whole beat
      push_exp(32'hDEADBEEF, 4'b1111, 1'b0);
      push_exp(32'h01020304, 4'b1111, 1'b1);
      send_hdr(2'd3, 32'hDEADBEEF, 4'b1111, e);
      chk("t3_err", e, 0);
      send_beat(32'h01020304, 4'hF, 1'b1);
      drain();
      chk("t3_pkt", pkt_cnt, 3);

      // Keep disagrees with count: flagged, count wins (3 header bytes)
      push_exp(32'hA1B2C344, 4'b1111, 1'b0);
      push_exp(32'h55667700, 4'b1110, 1'b1);
      send_hdr(2'd2, 32'h00A1B2C3, 4'b0011, e);
      chk("t4_err_pulse", e, 1);
      @(negedge clk);
      chk("t4_err_clear", err_keep, 0);
      @(posedge clk);
      #1;
      send_beat(32'h44556677, 4'hF, 1'b1);
      drain();
      chk("t4_pkt", pkt_cnt, 4);

      // Reset in the middle of a packet while the output is stalled
      rdy_force = 1'b0;
      send_hdr(2'd1, 32'h00001234, 4'b0011, e);
      send_beat(32'h11111111, 4'hF, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy_ins", ready_insert, 0);
      chk("mid_rst_rdy_in", ready_in, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_vld", valid_out, 0);
      chk("mid_rst_last", last_out, 0);
      chk("mid_rst_dat", data_out, 0);
      chk("mid_rst_keep", keep_out, 0);
      chk("mid_rst_pkt", pkt_cnt, 0);
      chk("mid_rst_rdy_ins1", ready_insert, 1);
      rdy_force = 1'b1;
      @(posedge clk);
      #1;

      // Fresh packet after reset, T==B exactly
      push_exp(32'hC0FFEEA0, 4'b1111, 1'b1);
      send_hdr(2'd2, 32'h00C0FFEE, 4'b0111, e);
      chk("t5_err", e, 0);
      send_beat(32'hA0B0C0D0, 4'b1000, 1'b1);
      drain();
      chk("t5_pkt", pkt_cnt, 1);

      // Random packets with 50% downstream stalls
      rand_rdy = 1'b1;
      for (int p = 0; p < 200; p++) begin
         int          n;
         int          nb;
         int          k;
         logic [31:0] hdr;
         logic [31:0] pd[4];
         logic [3:0]  pk[4];
         n   = $urandom_range(1, 4);
         nb  = $urandom_range(1, 4);
         k   = $urandom_range(1, 4);
         hdr = $urandom;
         mb.delete();
         for (int i = 0; i < n; i++) mb.push_back(hdr[8*(n-1-i) +: 8]);
         for (int j = 0; j < nb; j++) begin
            pd[j] = $urandom;
            pk[j] = (j == nb - 1) ? 4'(4'hF << (4 - k)) : 4'hF;
            for (int i = 0; i < 4; i++) begin
               if (pk[j][3-i]) mb.push_back(pd[j][31-8*i -: 8]);
            end
         end
         emit_model();
         send_hdr(2'(n - 1), hdr, 4'(4'hF >> (4 - n)), e);
         chk("rnd_err", e, 0);
         for (int j = 0; j < nb; j++) begin
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk);
               #1;
            end
            send_beat(pd[j], pk[j], j == nb - 1);
         end
      end
      drain();
      rand_rdy = 1'b0;
      chk("rnd_pkt", pkt_cnt, 201);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
